vcache_req_arbiter: RTL

VCACHE_REQ_ARBITER -- requirements
Module: vcache_req_arbiter

---
 rtl/vcache_req_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/vcache_req_arbiter.sv
// Round-robin request arbiter that lets several requesters share one vcache.
// Each grant pushes the winner's index into an in-order ID FIFO. Responses
// come back in request order, so the FIFO head names the owner of each
// response. Protocol violations set a sticky error flag.
module vcache_req_arbiter #(
    parameter int num_req_p    = 4,
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32,
    parameter int max_out_p    = 4
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [num_req_p-1:0]              req_v_i,
    input  logic [num_req_p-1:0]              req_op_i,
    input  logic [num_req_p*addr_width_p-1:0] req_addr_i,
    input  logic [num_req_p*data_width_p-1:0] req_data_i,
    output logic [num_req_p-1:0]              req_ready_o,
    output logic                              cache_v_o,
    output logic                              cache_op_o,
    output logic [addr_width_p-1:0]           cache_addr_o,
    output logic [data_width_p-1:0]           cache_data_o,
    input  logic                              cache_ready_i,
    input  logic                              cache_v_i,
    input  logic [data_width_p-1:0]           cache_data_i,
    output logic                              cache_yumi_o,
    output logic [num_req_p-1:0]              resp_v_o,
    output logic [data_width_p-1:0]           resp_data_o,
    input  logic [num_req_p-1:0]              resp_yumi_i,
    output logic                              err_o
);

    localparam int IdxW = $clog2(num_req_p);
    localparam int PtrW = $clog2(max_out_p);
    localparam int CntW = PtrW + 1;

    logic [IdxW-1:0] rr_q, rr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [IdxW-1:0] id_mem_q [max_out_p];
    logic [IdxW-1:0] id_mem_d [max_out_p];
    logic            err_q, err_d;

    logic            grant_ok;
    logic            found;
    logic            push;
    logic [IdxW-1:0] grant_idx;
    logic            fifo_empty;
    logic [IdxW-1:0] head_id;
    logic            pop;
    logic            err_set;

    // Round-robin search starting at rr_q; the grant is suppressed while in
    // reset, when the cache stalls, or when the registered count is full.
    always_comb begin
        int idx;
        idx       = 0;
        found     = 1'b0;
        grant_idx = '0;
        grant_ok  = ~reset_i & cache_ready_i & (count_q < CntW'(max_out_p));
        for (int k = 0; k < num_req_p; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= num_req_p) idx = idx - num_req_p;
            if (!found && req_v_i[IdxW'(idx)]) begin
                found     = 1'b1;
                grant_idx = IdxW'(idx);
            end
        end
        push = found & grant_ok;
    end

    // Zero-cycle grant path: forward the winner's request, zeros otherwise.
    always_comb begin
        req_ready_o  = '0;
        cache_v_o    = push;
        cache_op_o   = 1'b0;
        cache_addr_o = '0;
        cache_data_o = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (push && grant_idx == IdxW'(i)) begin
                req_ready_o[i] = 1'b1;
                cache_op_o     = req_op_i[i];
                cache_addr_o   = req_addr_i[i*addr_width_p +: addr_width_p];
                cache_data_o   = req_data_i[i*data_width_p +: data_width_p];
            end
        end
    end

    // Route each response to the requester named at the FIFO head and flag
    // responses with no owner or consumes of a response that isn't offered.
    always_comb begin
        fifo_empty = (count_q == '0);
        head_id    = id_mem_q[rd_ptr_q];
        resp_v_o   = '0;
        if (!reset_i && cache_v_i && !fifo_empty) resp_v_o[head_id] = 1'b1;
        pop          = ~reset_i & cache_v_i & ~fifo_empty & resp_yumi_i[head_id];
        cache_yumi_o = pop;
        resp_data_o  = cache_data_i;
        err_set      = (cache_v_i & fifo_empty) | (|(resp_yumi_i & ~resp_v_o));
        err_o        = err_q;
    end

    // Next-state for pointer, ID FIFO, count and sticky error.
    always_comb begin
        rr_d     = rr_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        id_mem_d = id_mem_q;
        err_d    = err_q | err_set;
        if (push) begin
            id_mem_d[wr_ptr_q] = grant_idx;
            wr_ptr_d           = wr_ptr_q + PtrW'(1);
            rr_d               = (grant_idx == IdxW'(num_req_p - 1)) ? '0 : grant_idx + IdxW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (push && !pop)      count_d = count_q + CntW'(1);
        else if (!push && pop) count_d = count_q - CntW'(1);
    end

    // Control state is reset; FIFO storage carries no reset since entries
    // are only ever read behind a valid count.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_q     <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_q     <= rr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
        id_mem_q <= id_mem_d;
    end

endmodule
